// File: rtl/fpu_tb_pkg.sv
// Shared types for the FPU stimulus/result alignment path: opcodes, rounding
// modes, the captured transaction record and the aligner state encoding.
package fpu_tb_pkg;

    localparam int FPU_W = 32;

    typedef enum logic [2:0] {
        FPU_ADD = 3'd0,
        FPU_SUB = 3'd1,
        FPU_MUL = 3'd2,
        FPU_DIV = 3'd3,
        FPU_I2F = 3'd4,
        FPU_F2I = 3'd5,
        FPU_REM = 3'd6
    } fpu_op_e;

    typedef enum logic [1:0] {
        RM_NEAREST = 2'd0,
        RM_ZERO    = 2'd1,
        RM_UP      = 2'd2,
        RM_DOWN    = 2'd3
    } fpu_rmode_e;

    typedef struct packed {
        logic [FPU_W-1:0] opA;
        logic [FPU_W-1:0] opB;
        fpu_op_e          op;
        fpu_rmode_e       rmode;
    } fpu_txn_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ERROR = 2'd2
    } align_state_e;

endpackage

// File: rtl/fpu_txn_fifo.sv
// In-order FIFO of pending FPU transactions; DEPTH must be a power of two so
// the pointers wrap naturally. clear_i empties it on the next edge.
module fpu_txn_fifo
    import fpu_tb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  fpu_txn_t                     wdata_i,
    output fpu_txn_t                     rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fpu_txn_t             mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 do_push;
    logic                 do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only entries behind a valid count are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fpu_stim_aligner.sv
// Pairs each returned FPU result with the oldest issued transaction and flags
// protocol faults. Optional statistics counters: define FPU_ALIGN_STATS_EN.
//
//   state    | meaning
//   ST_IDLE  | no transactions pending
//   ST_BUSY  | at least one transaction awaiting its result
//   ST_ERROR | orphan result or watchdog expiry; frozen until flush/reset
module fpu_stim_aligner
    import fpu_tb_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FPU_W-1:0]             in_opA,
    input  logic [FPU_W-1:0]             in_opB,
    input  logic [2:0]                   in_op,
    input  logic [1:0]                   in_rmode,
    input  logic                         res_valid,
    input  logic [FPU_W-1:0]             res_out,
    output logic                         out_valid,
    output logic [FPU_W-1:0]             out_opA,
    output logic [FPU_W-1:0]             out_opB,
    output logic [2:0]                   out_op,
    output logic [1:0]                   out_rmode,
    output logic [FPU_W-1:0]             out_fpuout,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         err_orphan,
    output logic                         err_timeout
`ifdef FPU_ALIGN_STATS_EN
    ,
    output logic [31:0]                  stat_issued,
    output logic [31:0]                  stat_retired,
    output logic [31:0]                  stat_max_pending
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int WD_W  = $clog2(TIMEOUT+1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT-1);
    localparam logic [CNT_W-1:0] ONE_LEFT = CNT_W'(1);

    align_state_e        state_q, state_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_orphan_q, err_timeout_q;
    logic                out_valid_q;
    fpu_txn_t            out_txn_q;
    logic [FPU_W-1:0]    out_res_q;

    fpu_txn_t            wr_txn;
    fpu_txn_t            head_txn;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                active, push, pop, orphan, timeout_hit;

    always_comb begin
        wr_txn       = '0;
        wr_txn.opA   = in_opA;
        wr_txn.opB   = in_opB;
        wr_txn.op    = fpu_op_e'(in_op);
        wr_txn.rmode = fpu_rmode_e'(in_rmode);
    end

    fpu_txn_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk),
        .clear_i (reset || flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_txn),
        .rdata_o (head_txn),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Flush outranks everything; in ERROR the FPU/generator handshakes are dead.
    assign active      = (state_q != ST_ERROR) && !flush;
    assign in_ready    = !fifo_full && (state_q != ST_ERROR);
    assign push        = in_valid && in_ready && !flush;
    assign pop         = active && res_valid && !fifo_empty;
    assign orphan      = active && res_valid && fifo_empty;
    assign timeout_hit = active && !fifo_empty && !res_valid && (wd_q == WD_LAST);

    always_comb begin
        wd_d = wd_q + WD_W'(1);
        if (state_q == ST_ERROR || fifo_empty || res_valid) wd_d = '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (push) state_d = ST_BUSY;
            ST_BUSY:  if (pop && !push && fifo_count == ONE_LEFT) state_d = ST_IDLE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
        if (orphan || timeout_hit) state_d = ST_ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wd_q          <= '0;
            err_orphan_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_txn_q     <= '0;
            out_res_q     <= '0;
        end else if (flush) begin
            state_q       <= ST_IDLE;
            wd_q          <= '0;
            err_orphan_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            err_orphan_q  <= err_orphan_q | orphan;
            err_timeout_q <= err_timeout_q | timeout_hit;
            out_valid_q   <= pop;
            if (pop) begin
                out_txn_q <= head_txn;
                out_res_q <= res_out;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_opA     = out_txn_q.opA;
    assign out_opB     = out_txn_q.opB;
    assign out_op      = out_txn_q.op;
    assign out_rmode   = out_txn_q.rmode;
    assign out_fpuout  = out_res_q;
    assign pending     = fifo_count;
    assign err_orphan  = err_orphan_q;
    assign err_timeout = err_timeout_q;

`ifdef FPU_ALIGN_STATS_EN
    // Statistics survive flush so a whole run can be summarised.
    logic [31:0] stat_issued_q, stat_retired_q, stat_max_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued_q  <= '0;
            stat_retired_q <= '0;
            stat_max_q     <= '0;
        end else begin
            if (push && stat_issued_q != '1)        stat_issued_q  <= stat_issued_q + 32'd1;
            if (out_valid_q && stat_retired_q != '1) stat_retired_q <= stat_retired_q + 32'd1;
            if (32'(fifo_count) > stat_max_q)       stat_max_q     <= 32'(fifo_count);
        end
    end

    assign stat_issued      = stat_issued_q;
    assign stat_retired     = stat_retired_q;
    assign stat_max_pending = stat_max_q;
`endif

endmodule

// File: tb/tb_fpu_stim_aligner.sv
// Directed bench for fpu_stim_aligner: a vector table for the basic flow and
// hand-written sequences for full/wrap, watchdog and statistics behaviour.
module tb_fpu_stim_aligner;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, res_valid;
    logic [31:0] in_opA, in_opB, res_out;
    logic [2:0]  in_op;
    logic [1:0]  in_rmode;
    logic        in_ready, out_valid, err_orphan, err_timeout;
    logic [31:0] out_opA, out_opB, out_fpuout;
    logic [2:0]  out_op;
    logic [1:0]  out_rmode;
    logic [3:0]  pending;
`ifdef FPU_ALIGN_STATS_EN
    logic [31:0] stat_issued, stat_retired, stat_max_pending;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpu_stim_aligner #(.DEPTH(8), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opA      (in_opA),
        .in_opB      (in_opB),
        .in_op       (in_op),
        .in_rmode    (in_rmode),
        .res_valid   (res_valid),
        .res_out     (res_out),
        .out_valid   (out_valid),
        .out_opA     (out_opA),
        .out_opB     (out_opB),
        .out_op      (out_op),
        .out_rmode   (out_rmode),
        .out_fpuout  (out_fpuout),
        .pending     (pending),
        .err_orphan  (err_orphan),
        .err_timeout (err_timeout)
`ifdef FPU_ALIGN_STATS_EN
        ,
        .stat_issued      (stat_issued),
        .stat_retired     (stat_retired),
        .stat_max_pending (stat_max_pending)
`endif
    );

    typedef struct {
        logic        iv;
        logic [31:0] a, b;
        logic [2:0]  op;
        logic [1:0]  rm;
        logic        rv;
        logic [31:0] res;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_a, e_b;
        logic [2:0]  e_op;
        logic [1:0]  e_rm;
        logic [31:0] e_res;
        logic [3:0]  e_pend;
        logic        e_rdy, e_orph, e_to;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] mq [$];
    logic [31:0] exp_a;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        res_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        step();
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst pending", 64'(pending), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst errs", 64'({err_orphan, err_timeout}), 64'd0);
        chk("rst out_opA", 64'(out_opA), 64'd0);
        chk("rst out_fpuout", 64'(out_fpuout), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        //           iv a            b            op    rm    rv res          fl   ov a            b            op    rm    res          pnd   rdy orph to
        vecs[0]  = '{1, 32'h3F800000, 32'h40000000, 3'd0, 2'd0, 0, 32'h0,        0,  0, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        4'd1, 1, 0, 0};
        vecs[1]  = '{1, 32'h40400000, 32'h40000000, 3'd2, 2'd1, 0, 32'h0,        0,  0, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        4'd2, 1, 0, 0};
        vecs[2]  = '{1, 32'h40C00000, 32'h40000000, 3'd3, 2'd2, 0, 32'h0,        0,  0, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        4'd3, 1, 0, 0};
        vecs[3]  = '{0, 32'h0,        32'h0,        3'd0, 2'd0, 0, 32'h0,        0,  0, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        4'd3, 1, 0, 0};
        vecs[4]  = '{0, 32'h0,        32'h0,        3'd0, 2'd0, 1, 32'h40400000, 0,  1, 32'h3F800000, 32'h40000000, 3'd0, 2'd0, 32'h40400000, 4'd2, 1, 0, 0};
        vecs[5]  = '{0, 32'h0,        32'h0,        3'd0, 2'd0, 0, 32'h0,        0,  0, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        4'd2, 1, 0, 0};
        vecs[6]  = '{0, 32'h0,        32'h0,        3'd0, 2'd0, 1, 32'h40C00000, 0,  1, 32'h40400000, 32'h40000000, 3'd2, 2'd1, 32'h40C00000, 4'd1, 1, 0, 0};
        vecs[7]  = '{0, 32'h0,        32'h0,        3'd0, 2'd0, 1, 32'h40400000, 0,  1, 32'h40C00000, 32'h40000000, 3'd3, 2'd2, 32'h40400000, 4'd0, 1, 0, 0};
        vecs[8]  = '{0, 32'h0,        32'h0,        3'd0, 2'd0, 0, 32'h0,        0,  0, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        4'd0, 1, 0, 0};
        vecs[9]  = '{0, 32'h0,        32'h0,        3'd0, 2'd0, 1, 32'h12345678, 0,  0, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        4'd0, 0, 1, 0};
        vecs[10] = '{1, 32'h1,        32'h2,        3'd1, 2'd3, 1, 32'h9,        0,  0, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        4'd0, 0, 1, 0};
        vecs[11] = '{0, 32'h0,        32'h0,        3'd0, 2'd0, 0, 32'h0,        1,  0, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        4'd0, 1, 0, 0};
        vecs[12] = '{1, 32'h5,        32'h6,        3'd4, 2'd0, 0, 32'h0,        1,  0, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        4'd0, 1, 0, 0};
        vecs[13] = '{1, 32'h7,        32'h8,        3'd5, 2'd1, 0, 32'h0,        0,  0, 32'h0,        32'h0,        3'd0, 2'd0, 32'h0,        4'd1, 1, 0, 0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; res_valid = 1'b0;
        in_opA = '0; in_opB = '0; in_op = '0; in_rmode = '0; res_out = '0;

        // Basic in-order flow, orphan detection, ERROR freeze and flush priority.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            in_valid = vecs[i].iv; in_opA = vecs[i].a; in_opB = vecs[i].b;
            in_op = vecs[i].op; in_rmode = vecs[i].rm;
            res_valid = vecs[i].rv; res_out = vecs[i].res; flush = vecs[i].fl;
            step();
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d pending", i), 64'(pending), 64'(vecs[i].e_pend));
            chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
            chk($sformatf("v%0d err_orphan", i), 64'(err_orphan), 64'(vecs[i].e_orph));
            chk($sformatf("v%0d err_timeout", i), 64'(err_timeout), 64'(vecs[i].e_to));
            if (vecs[i].e_ov) begin
                chk($sformatf("v%0d out_opA", i), 64'(out_opA), 64'(vecs[i].e_a));
                chk($sformatf("v%0d out_opB", i), 64'(out_opB), 64'(vecs[i].e_b));
                chk($sformatf("v%0d out_op", i), 64'(out_op), 64'(vecs[i].e_op));
                chk($sformatf("v%0d out_rmode", i), 64'(out_rmode), 64'(vecs[i].e_rm));
                chk($sformatf("v%0d out_fpuout", i), 64'(out_fpuout), 64'(vecs[i].e_res));
            end
        end
        idle();

        // Fill to DEPTH, pop while full, then push+pop through the pointer wrap.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_opA = 32'(i); in_opB = 32'h40000000; in_op = 3'd0; in_rmode = 2'd0;
            step();
            mq.push_back(32'(i));
        end
        idle();
        chk("full pending", 64'(pending), 64'd8);
        chk("full in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_opA = 32'hDEAD; res_valid = 1'b1; res_out = 32'hAAAA0000;
        step();
        exp_a = mq.pop_front();
        chk("full pop out_valid", 64'(out_valid), 64'd1);
        chk("full pop out_opA", 64'(out_opA), 64'(exp_a));
        chk("full pop out_fpuout", 64'(out_fpuout), 64'hAAAA0000);
        chk("full pop pending", 64'(pending), 64'd7);
        chk("full pop in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            res_valid = 1'b1; res_out = 32'h1000 + 32'(k);
            step();
            exp_a = mq.pop_front();
            chk($sformatf("drain%0d out_opA", k), 64'(out_opA), 64'(exp_a));
        end
        chk("pre-wrap pending", 64'(pending), 64'd3);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_opA = 32'd100 + 32'(k);
            res_valid = 1'b1; res_out = 32'h2000 + 32'(k);
            step();
            exp_a = mq.pop_front();
            mq.push_back(32'd100 + 32'(k));
            chk($sformatf("wrap%0d out_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("wrap%0d out_opA", k), 64'(out_opA), 64'(exp_a));
            chk($sformatf("wrap%0d out_fpuout", k), 64'(out_fpuout), 64'h2000 + 64'(k));
            chk($sformatf("wrap%0d pending", k), 64'(pending), 64'd3);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            res_valid = 1'b1; res_out = 32'h3000;
            step();
            exp_a = mq.pop_front();
            chk($sformatf("tail%0d out_opA", k), 64'(out_opA), 64'(exp_a));
        end
        idle();
        step();
        chk("tail out_valid", 64'(out_valid), 64'd0);
        chk("tail pending", 64'(pending), 64'd0);

        // Watchdog: expires exactly TIMEOUT cycles after the push edge.
        do_reset();
        in_valid = 1'b1; in_opA = 32'h3F800000;
        step();
        in_valid = 1'b0;
        for (int k = 1; k < 16; k++) step();
        chk("wd cycle15 err_timeout", 64'(err_timeout), 64'd0);
        step();
        chk("wd cycle16 err_timeout", 64'(err_timeout), 64'd1);
        chk("wd in_ready", 64'(in_ready), 64'd0);
        chk("wd err_orphan", 64'(err_orphan), 64'd0);
        res_valid = 1'b1; res_out = 32'h40000000;
        step();
        res_valid = 1'b0;
        chk("wd late out_valid", 64'(out_valid), 64'd0);
        chk("wd late pending", 64'(pending), 64'd1);
        step();
        chk("wd late out_valid2", 64'(out_valid), 64'd0);
        chk("wd sticky", 64'(err_timeout), 64'd1);

`ifdef FPU_ALIGN_STATS_EN
        do_reset();
        chk("stat rst issued", 64'(stat_issued), 64'd0);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_opA = 32'(k);
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            res_valid = 1'b1; res_out = 32'(k);
            step();
        end
        idle();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("stat issued", 64'(stat_issued), 64'd5);
        chk("stat retired", 64'(stat_retired), 64'd5);
        chk("stat max_pending", 64'(stat_max_pending), 64'd5);
        chk("stat pending", 64'(pending), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_stim_aligner.md
Name: fpu_stim_aligner

Overview:
- Sits between the stimulus generator and the combinational checker in the FPU verification environment.
- Captures each issued FPU transaction (opA, opB, op, rounding mode) in an in-order FIFO while the pipelined FPU computes.
- Pairs the oldest pending transaction with each returned FPU result and presents the aligned set to the checker for one cycle.
- Provides sticky error flags for protocol faults (orphan result, watchdog timeout).

Parameters:
- DEPTH, 8: pending-transaction FIFO depth; power of 2, minimum 2.
- TIMEOUT, 64: maximum consecutive cycles with pending > 0 and no res_valid before timeout.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO, state and error flags.
- in_valid  in  1  generator transaction valid.
- in_ready  out  1  FIFO can accept a transaction.
- in_opA  in  32  operand A, IEEE-754 single.
- in_opB  in  32  operand B, IEEE-754 single.
- in_op  in  3  FPU opcode (fpu_op_e).
- in_rmode  in  2  rounding mode.
- res_valid  in  1  FPU result valid; never backpressured.
- res_out  in  32  FPU result.
- out_valid  out  1  aligned set valid, one-cycle pulse.
- out_opA  out  32  operand A of the aligned set.
- out_opB  out  32  operand B of the aligned set.
- out_op  out  3  opcode of the aligned set.
- out_rmode  out  2  rounding mode of the aligned set.
- out_fpuout  out  32  FPU result of the aligned set.
- pending  out  $clog2(DEPTH+1)  occupancy count.
- err_orphan  out  1  sticky: result received with FIFO empty.
- err_timeout  out  1  sticky: watchdog expired.

Behaviour:
- Reset: all outputs 0 except in_ready=1; pointers, count and watchdog cleared; state IDLE. A reset mid-operation discards pending entries at the next edge.
- Push: in_valid && in_ready at a posedge writes {opA, opB, op, rmode} at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- in_ready = (count != DEPTH) && (state != ERROR). Combinational from registered state.
- Pop: res_valid at a posedge with count > 0 reads the head entry. The cycle after res_valid, out_valid=1 with the head fields and registered res_out; otherwise out_valid=0. Latency is exactly 1 cycle.
- Same-cycle push + pop: both occur; count unchanged. A same-cycle push is never matched to the same-cycle result; the FPU has a minimum latency of 1.
- Full: no push, because in_ready is low; a pop is still allowed.
- Empty + res_valid (orphan): err_orphan set, state goes to ERROR, no out_valid.
- Watchdog: counts consecutive cycles with count > 0 and !res_valid. It resets on res_valid or when count==0. When it reaches TIMEOUT, err_timeout is set and state goes to ERROR.
- FSM:
  - IDLE (count==0) -> BUSY on push.
  - BUSY -> IDLE when count reaches 0.
  - BUSY or IDLE -> ERROR on either error.
  - ERROR holds, ignoring res_valid and in_valid, until flush or reset.
- flush: same effect as reset on FIFO, state, watchdog and error flags; flush has priority over push/pop in the same cycle; out_valid=0 the next cycle.
- Both errors in the same cycle set both flags.

Optional Feature:
- Macro FPU_ALIGN_STATS_EN.
- When defined: adds 32-bit outputs stat_issued (push count) and stat_retired (out_valid count), plus stat_max_pending (high-water mark of count). These are cleared only by reset, not by flush, and saturate at all-ones.
- When undefined: none of these ports or registers exist.

Decomposition:
- Shared package fpu_tb_pkg:
  - fpu_op_e: 3-bit opcode enum (ADD=0, SUB=1, MUL=2, DIV=3, I2F=4, F2I=5, REM=6).
  - fpu_rmode_e: 2-bit rounding-mode enum.
  - fpu_txn_t: packed struct {opA, opB, op, rmode}.
  - Constant FPU_W=32.
- One natural sub-module, fpu_txn_fifo: parameterised synchronous FIFO of fpu_txn_t with push, pop, full, empty and count outputs. The aligner holds the FSM, watchdog and output register.

Test Plan:
- Reset; push 3 transactions (3F800000+40000000 op=000, 40400000*40000000 op=010, 40C00000/40000000 op=011); later res_valid with 40400000, 40C00000, 40400000 -> three out_valid pulses, each 1 cycle after its res_valid, fields in push order; pending ends 0.
- DEPTH=8: push 8 with no results -> pending=8, in_ready=0. Then res_valid with in_valid=1 in the same cycle -> no push, pending=7, in_ready=1 next cycle.
- pending=3: simultaneous push and res_valid for 5 cycles -> pending stays 3, out order matches push order, wr/rd pointers wrap past 7 correctly.
- res_valid at pending=0 -> err_orphan=1, state ERROR, in_ready=0, no out_valid. Then flush -> err_orphan=0, in_ready=1, pending=0.
- TIMEOUT=16: push 1, withhold the result -> err_timeout=1 exactly 16 cycles after the push, in_ready=0. A late res_valid is ignored.
- FPU_ALIGN_STATS_EN: push 5 and retire 5, then flush -> stat_issued=5, stat_retired=5, stat_max_pending=5 (or the observed peak), all unchanged by the flush.
